// File: rtl/nav_arb_pkg.sv
// Shared types and constants for the navigate command-port arbiter.
package nav_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CMD = 1'b0,
    OWN_SLV = 1'b1
  } arb_owner_t;

  typedef enum logic {
    OP_HDNG = 1'b0,
    OP_MV   = 1'b1
  } arb_op_t;

  localparam int unsigned TMO_FAST = 2**16;
  localparam int unsigned TMO_FULL = 2**26;

  // Watchdog counter width; the counter saturates at all-ones, which is TMO-1.
  function automatic int unsigned wdog_width(input int fast_sim);
    if (fast_sim != 0) begin
      wdog_width = $clog2(TMO_FAST);
    end else begin
      wdog_width = $clog2(TMO_FULL);
    end
  endfunction

endpackage

// File: rtl/nav_wdog.sv
// Saturating completion watchdog: cleared on a new grant, counts while enabled,
// and flags expiry once the count reaches its all-ones ceiling.
module nav_wdog #(
  parameter int unsigned W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  // Count enabled clocks; clear has priority and the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign expired = (count == CNT_MAX);

endmodule

// File: rtl/nav_arbiter.sv
// Arbitrates navigate's command port between cmd_proc and maze_solve,
// issues one-clock start pulses, holds the move parameters, routes the
// completion back to the owning requester and guards against a lost completion.
module nav_arbiter
  import nav_arb_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_md,
  input  logic        c_strt_hdng,
  input  logic        c_strt_mv,
  input  logic [11:0] c_hdng,
  input  logic        c_stp_lft,
  input  logic        c_stp_rght,
  input  logic        s_strt_hdng,
  input  logic        s_strt_mv,
  input  logic [11:0] s_hdng,
  input  logic        s_stp_lft,
  input  logic        s_stp_rght,
  input  logic        mv_cmplt,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic [11:0] dsrd_hdng,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic        c_mv_cmplt,
  output logic        s_mv_cmplt,
  output logic        busy,
  output logic        tmo,
  output logic        req_drop
);

  localparam int unsigned WD_W = wdog_width(FAST_SIM);

  arb_state_t  state;
  arb_owner_t  owner;

  logic        elig_hdng;
  logic        elig_mv;
  logic        elig_req;
  logic        inelig_req;
  logic [11:0] elig_hdng_val;
  logic        elig_stp_lft;
  logic        elig_stp_rght;
  arb_op_t     req_op;
  logic        grant;
  logic        drop;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_expired;

  // Select the eligible requester and decide grant/discard for this clock.
  always_comb begin
    elig_hdng     = 1'b0;
    elig_mv       = 1'b0;
    inelig_req    = 1'b0;
    elig_hdng_val = 12'h000;
    elig_stp_lft  = 1'b0;
    elig_stp_rght = 1'b0;
    if (cmd_md) begin
      elig_hdng     = c_strt_hdng;
      elig_mv       = c_strt_mv;
      inelig_req    = s_strt_hdng | s_strt_mv;
      elig_hdng_val = c_hdng;
      elig_stp_lft  = c_stp_lft;
      elig_stp_rght = c_stp_rght;
    end else begin
      elig_hdng     = s_strt_hdng;
      elig_mv       = s_strt_mv;
      inelig_req    = c_strt_hdng | c_strt_mv;
      elig_hdng_val = s_hdng;
      elig_stp_lft  = s_stp_lft;
      elig_stp_rght = s_stp_rght;
    end
    elig_req = elig_hdng | elig_mv;
    // A heading request wins when both arrive together from one source.
    if (elig_hdng) begin
      req_op = OP_HDNG;
    end else begin
      req_op = OP_MV;
    end
    grant = (state == IDLE) && elig_req;
    // Discard: wrong requester, anything outside IDLE, or the losing half of a dual request.
    drop  = inelig_req
          | (elig_req && (state != IDLE))
          | (grant && elig_hdng && elig_mv);
    wd_clr = grant;
    wd_en  = (state == ISSUE) || (state == BUSY);
  end

  nav_wdog #(
    .W (WD_W)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Operation FSM with registered pulses, latched parameters and owner routing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_CMD;
      strt_hdng  <= 1'b0;
      strt_mv    <= 1'b0;
      dsrd_hdng  <= 12'h000;
      stp_lft    <= 1'b0;
      stp_rght   <= 1'b0;
      c_mv_cmplt <= 1'b0;
      s_mv_cmplt <= 1'b0;
      busy       <= 1'b0;
      tmo        <= 1'b0;
      req_drop   <= 1'b0;
    end else begin
      strt_hdng  <= 1'b0;
      strt_mv    <= 1'b0;
      c_mv_cmplt <= 1'b0;
      s_mv_cmplt <= 1'b0;
      tmo        <= 1'b0;
      req_drop   <= drop;
      case (state)
        IDLE: begin
          if (grant) begin
            owner     <= cmd_md ? OWN_CMD : OWN_SLV;
            dsrd_hdng <= elig_hdng_val;
            stp_lft   <= elig_stp_lft;
            stp_rght  <= elig_stp_rght;
            strt_hdng <= (req_op == OP_HDNG);
            strt_mv   <= (req_op == OP_MV);
            busy      <= 1'b1;
            state     <= ISSUE;
          end else begin
            state     <= IDLE;
          end
        end
        ISSUE: begin
          state <= BUSY;
        end
        BUSY: begin
          // A real completion takes precedence over a coincident expiry.
          if (mv_cmplt || wd_expired) begin
            tmo        <= ~mv_cmplt;
            c_mv_cmplt <= (owner == OWN_CMD);
            s_mv_cmplt <= (owner == OWN_SLV);
            state      <= DONE;
          end else begin
            state      <= BUSY;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nav_arbiter.sv
// Directed self-checking bench for nav_arbiter.
module tb_nav_arbiter;

  localparam int TMO = 65536;

  logic        clk;
  logic        rst_n;
  logic        cmd_md;
  logic        c_strt_hdng, c_strt_mv, c_stp_lft, c_stp_rght;
  logic [11:0] c_hdng;
  logic        s_strt_hdng, s_strt_mv, s_stp_lft, s_stp_rght;
  logic [11:0] s_hdng;
  logic        mv_cmplt;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght;
  logic [11:0] dsrd_hdng;
  logic        c_mv_cmplt, s_mv_cmplt, busy, tmo, req_drop;

  int checks = 0;
  int errors = 0;

  nav_arbiter #(.FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md),
    .c_strt_hdng(c_strt_hdng), .c_strt_mv(c_strt_mv), .c_hdng(c_hdng),
    .c_stp_lft(c_stp_lft), .c_stp_rght(c_stp_rght),
    .s_strt_hdng(s_strt_hdng), .s_strt_mv(s_strt_mv), .s_hdng(s_hdng),
    .s_stp_lft(s_stp_lft), .s_stp_rght(s_stp_rght),
    .mv_cmplt(mv_cmplt),
    .strt_hdng(strt_hdng), .strt_mv(strt_mv), .dsrd_hdng(dsrd_hdng),
    .stp_lft(stp_lft), .stp_rght(stp_rght),
    .c_mv_cmplt(c_mv_cmplt), .s_mv_cmplt(s_mv_cmplt),
    .busy(busy), .tmo(tmo), .req_drop(req_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    c_strt_hdng = 1'b0; c_strt_mv = 1'b0;
    s_strt_hdng = 1'b0; s_strt_mv = 1'b0;
    mv_cmplt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_md = 1'b1;
    clear_reqs();
    c_hdng = 12'h000; c_stp_lft = 1'b0; c_stp_rght = 1'b0;
    s_hdng = 12'h000; s_stp_lft = 1'b0; s_stp_rght = 1'b0;
    step(); step();
    checks++;
    if ({strt_hdng, strt_mv, stp_lft, stp_rght, c_mv_cmplt, s_mv_cmplt, busy, tmo, req_drop, dsrd_hdng} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {strt_hdng, strt_mv, stp_lft, stp_rght, c_mv_cmplt, s_mv_cmplt, busy, tmo, req_drop, dsrd_hdng});
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_cmd_heading();
    bit bad;
    cmd_md = 1'b1; c_strt_hdng = 1'b1; c_hdng = 12'h3FF;
    step();
    clear_reqs();
    checks++;
    if ({strt_hdng, strt_mv, busy, dsrd_hdng} !== {1'b1, 1'b0, 1'b1, 12'h3FF}) begin
      errors++;
      $display("FAIL t1_issue: got hdng=%b mv=%b busy=%b dsrd=%h expected 1 0 1 3ff", strt_hdng, strt_mv, busy, dsrd_hdng);
    end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (strt_hdng || c_mv_cmplt || s_mv_cmplt || !busy) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL t1_busy_wait: got glitch=%b expected 0", bad);
    end
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    checks++;
    if ({c_mv_cmplt, s_mv_cmplt, busy, tmo} !== 4'b1010) begin
      errors++;
      $display("FAIL t1_complete: got c=%b s=%b busy=%b tmo=%b expected 1 0 1 0", c_mv_cmplt, s_mv_cmplt, busy, tmo);
    end
    step();
    checks++;
    if ({c_mv_cmplt, busy} !== 2'b00) begin
      errors++;
      $display("FAIL t1_idle: got c=%b busy=%b expected 0 0", c_mv_cmplt, busy);
    end
  endtask

  task automatic test_slv_move_and_drop();
    bit bad;
    cmd_md = 1'b0;
    s_strt_mv = 1'b1; s_stp_lft = 1'b1; s_stp_rght = 1'b0; s_hdng = 12'h155;
    c_strt_mv = 1'b1;
    step();
    clear_reqs();
    checks++;
    if ({strt_mv, strt_hdng, stp_lft, stp_rght, req_drop, dsrd_hdng} !== {5'b10101, 12'h155}) begin
      errors++;
      $display("FAIL t2_issue: got mv=%b hd=%b sl=%b sr=%b drop=%b dsrd=%h expected 1 0 1 0 1 155",
               strt_mv, strt_hdng, stp_lft, stp_rght, req_drop, dsrd_hdng);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!stp_lft || strt_mv || req_drop) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL t2_hold: got glitch=%b expected 0", bad);
    end
    // Request during BUSY is discarded and must not disturb the latched heading.
    s_strt_hdng = 1'b1; s_hdng = 12'hC00;
    step();
    clear_reqs();
    checks++;
    if ({req_drop, strt_hdng, dsrd_hdng} !== {2'b10, 12'h155}) begin
      errors++;
      $display("FAIL t3_busy_drop: got drop=%b hd=%b dsrd=%h expected 1 0 155", req_drop, strt_hdng, dsrd_hdng);
    end
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    checks++;
    if ({s_mv_cmplt, c_mv_cmplt} !== 2'b10) begin
      errors++;
      $display("FAIL t2_complete: got s=%b c=%b expected 1 0", s_mv_cmplt, c_mv_cmplt);
    end
    step();
    checks++;
    if ({busy, dsrd_hdng, stp_lft} !== {1'b0, 12'h155, 1'b1}) begin
      errors++;
      $display("FAIL t3_idle_hold: got busy=%b dsrd=%h sl=%b expected 0 155 1", busy, dsrd_hdng, stp_lft);
    end
    s_strt_hdng = 1'b1; s_hdng = 12'h2AA; s_stp_lft = 1'b0;
    step();
    clear_reqs();
    checks++;
    if ({strt_hdng, req_drop, stp_lft, dsrd_hdng} !== {3'b100, 12'h2AA}) begin
      errors++;
      $display("FAIL t3_regrant: got hd=%b drop=%b sl=%b dsrd=%h expected 1 0 0 2aa", strt_hdng, req_drop, stp_lft, dsrd_hdng);
    end
    step();
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    step();
  endtask

  task automatic test_mode_flip();
    cmd_md = 1'b0; s_strt_mv = 1'b1;
    step();
    clear_reqs();
    step();
    cmd_md = 1'b1;
    step(); step();
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    checks++;
    if ({s_mv_cmplt, c_mv_cmplt} !== 2'b10) begin
      errors++;
      $display("FAIL t4_owner: got s=%b c=%b expected 1 0", s_mv_cmplt, c_mv_cmplt);
    end
    step();
    // Stray completion in IDLE must produce nothing.
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    checks++;
    if ({s_mv_cmplt, c_mv_cmplt, busy, tmo} !== 4'b0000) begin
      errors++;
      $display("FAIL t4_stray_cmplt: got s=%b c=%b busy=%b tmo=%b expected 0 0 0 0", s_mv_cmplt, c_mv_cmplt, busy, tmo);
    end
  endtask

  task automatic test_dual_request();
    cmd_md = 1'b1; c_strt_hdng = 1'b1; c_strt_mv = 1'b1; c_hdng = 12'h801;
    step();
    clear_reqs();
    checks++;
    if ({strt_hdng, strt_mv, req_drop, dsrd_hdng} !== {3'b101, 12'h801}) begin
      errors++;
      $display("FAIL dual_req: got hd=%b mv=%b drop=%b dsrd=%h expected 1 0 1 801", strt_hdng, strt_mv, req_drop, dsrd_hdng);
    end
    step();
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    int tmo_seen;
    cmd_md = 1'b1; c_strt_mv = 1'b1;
    step();   // ISSUE visible
    clear_reqs();
    tmo_seen = 0;
    for (int i = 1; i < TMO; i++) begin
      step();
      if (tmo || c_mv_cmplt) tmo_seen = i;
    end
    checks++;
    if (tmo_seen !== 0) begin
      errors++;
      $display("FAIL t5_early_tmo: got pulse at clk %0d expected none", tmo_seen);
    end
    step();   // TMO clocks after ISSUE
    checks++;
    if ({tmo, c_mv_cmplt, s_mv_cmplt, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL t5_tmo: got tmo=%b c=%b s=%b busy=%b expected 1 1 0 1", tmo, c_mv_cmplt, s_mv_cmplt, busy);
    end
    step();
    checks++;
    if ({tmo, c_mv_cmplt, busy} !== 3'b000) begin
      errors++;
      $display("FAIL t5_release: got tmo=%b c=%b busy=%b expected 0 0 0", tmo, c_mv_cmplt, busy);
    end
    // Coincident completion and expiry: jump the counter near its ceiling.
    c_strt_mv = 1'b1;
    step();
    clear_reqs();
    step();
    force dut.u_wdog.count = 16'hFFFB;
    #1;
    release dut.u_wdog.count;
    step(); step(); step(); step();   // count now 16'hFFFF
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    checks++;
    if ({tmo, c_mv_cmplt} !== 2'b01) begin
      errors++;
      $display("FAIL t5_coincident: got tmo=%b c=%b expected 0 1", tmo, c_mv_cmplt);
    end
    step();
  endtask

  task automatic test_async_reset();
    cmd_md = 1'b0; s_strt_hdng = 1'b1; s_hdng = 12'h777; s_stp_rght = 1'b1;
    step();
    clear_reqs();
    step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({strt_hdng, strt_mv, stp_lft, stp_rght, c_mv_cmplt, s_mv_cmplt, busy, tmo, req_drop, dsrd_hdng} !== 21'd0) begin
      errors++;
      $display("FAIL t6_async_reset: got %b expected all zero",
               {strt_hdng, strt_mv, stp_lft, stp_rght, c_mv_cmplt, s_mv_cmplt, busy, tmo, req_drop, dsrd_hdng});
    end
    step();
    #2 rst_n = 1'b1;
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    step();
    checks++;
    if ({s_mv_cmplt, c_mv_cmplt, busy} !== 3'b000) begin
      errors++;
      $display("FAIL t6_no_cmplt: got s=%b c=%b busy=%b expected 0 0 0", s_mv_cmplt, c_mv_cmplt, busy);
    end
    s_strt_mv = 1'b1; s_hdng = 12'h0F0;
    step();
    clear_reqs();
    checks++;
    if ({strt_mv, busy, dsrd_hdng} !== {2'b11, 12'h0F0}) begin
      errors++;
      $display("FAIL t6_regrant: got mv=%b busy=%b dsrd=%h expected 1 1 0f0", strt_mv, busy, dsrd_hdng);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_heading();
    test_slv_move_and_drop();
    test_mode_flip();
    test_dual_request();
    test_watchdog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
